// File: rtl/buf_pp_bank.sv
// N-bank ping-pong operand buffer: DMA load side fills banks in order, compute side reads and releases them.
// Latency: a load write lands on the accepting edge; ex_data/ex_data_vld appear RD_LAT cycles after an accepted read.
// Backpressure: ld_ready drops while the current load bank is still full; ex_bank_rdy stays low until a filled bank is released to exec.
module buf_pp_bank #(
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_ld_valid,
  output logic                                 o_ld_ready,
  input  logic [ADDR_WIDTH-1:0]                i_ld_addr,
  input  logic [DATA_WIDTH-1:0]                i_ld_data,
  input  logic                                 i_ld_last,
  output logic                                 o_ex_bank_rdy,
  input  logic                                 i_ex_rd_en,
  input  logic [ADDR_WIDTH-1:0]                i_ex_addr,
  output logic [DATA_WIDTH-1:0]                o_ex_data,
  output logic                                 o_ex_data_vld,
  input  logic                                 i_ex_done,
  output logic [$clog2(NUM_BANKS+1)-1:0]       o_full_cnt
);

  localparam int PW    = $clog2(NUM_BANKS);
  localparam int CW    = $clog2(NUM_BANKS + 1);
  localparam int PAW   = PW + ADDR_WIDTH;
  localparam int DEPTH = NUM_BANKS * (2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Bank ownership: a set bit means the bank is loaded and belongs to exec.
  logic [NUM_BANKS-1:0]  r_full;
  logic [PW-1:0]         r_ld_ptr;
  logic [PW-1:0]         r_ex_ptr;

  // Storage is deliberately not reset; ownership guarantees no stale reads.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Read pipeline: stage 0 is the RAM output register, later stages add latency.
  logic [RD_LAT-1:0]     r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_dat [RD_LAT];

  logic                  w_ld_acc;
  logic                  w_ld_fin;
  logic                  w_rd_acc;
  logic                  w_rel;
  logic [PAW-1:0]        w_wr_addr;
  logic [PAW-1:0]        w_rd_addr;
  logic [NUM_BANKS-1:0]  w_full_nxt;
  logic [CW-1:0]         w_cnt;

  assign o_ld_ready    = !r_full[r_ld_ptr];
  assign o_ex_bank_rdy = r_full[r_ex_ptr];
  assign w_ld_acc      = i_ld_valid && o_ld_ready;
  assign w_ld_fin      = w_ld_acc && i_ld_last;
  assign w_rd_acc      = i_ex_rd_en && o_ex_bank_rdy;
  assign w_rel         = i_ex_done && o_ex_bank_rdy;
  assign w_wr_addr     = {r_ld_ptr, i_ld_addr};
  assign w_rd_addr     = {r_ex_ptr, i_ex_addr};
  assign o_ex_data     = r_rd_dat[RD_LAT-1];
  assign o_ex_data_vld = r_rd_vld[RD_LAT-1];
  assign o_full_cnt    = w_cnt;

  // Next ownership map; load completion and release always hit different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_ld_fin) w_full_nxt[r_ld_ptr] = 1'b1;
    if (w_rel)    w_full_nxt[r_ex_ptr] = 1'b0;
  end

  // Population count of full banks.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_cnt = w_cnt + CW'(r_full[i]);
    end
  end

  // Ownership flags and bank pointers; pointers wrap naturally (power-of-two bank count).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_full   <= '0;
      r_ld_ptr <= '0;
      r_ex_ptr <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_ld_fin) r_ld_ptr <= r_ld_ptr + PTR_ONE;
      if (w_rel)    r_ex_ptr <= r_ex_ptr + PTR_ONE;
    end
  end

  // Single write port, driven only by accepted load words.
  always_ff @(posedge i_clk) begin
    if (w_ld_acc) r_mem[w_wr_addr] <= i_ld_data;
  end

  // Read port and latency pipeline; data stages only move with a valid so ex_data holds between reads.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) r_rd_dat[k] <= '0;
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      if (w_rd_acc) r_rd_dat[0] <= r_mem[w_rd_addr];
      for (int k = 1; k < RD_LAT; k++) begin
        r_rd_vld[k] <= r_rd_vld[k-1];
        if (r_rd_vld[k-1]) r_rd_dat[k] <= r_rd_dat[k-1];
      end
    end
  end

endmodule

// File: tb/tb_buf_pp_bank.sv
// Directed bench: three buffers (RD_LAT 1, 2, 3) share one stimulus stream.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stall, drop and same-cycle release cases are driven explicitly.
module tb_buf_pp_bank;

  logic       clk;
  logic       rst_n;
  logic       ld_valid;
  logic [9:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ex_rd_en;
  logic [9:0] ex_addr;
  logic       ex_done;

  wire [2:0]  ldr;
  wire [2:0]  exr;
  wire [2:0]  vld;
  wire [23:0] dat_all;
  wire [5:0]  cnt_all;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       ld_valid;
    logic [9:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ex_done;
    logic       exp_ldr;
    logic       exp_exr;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  buf_pp_bank #(.NUM_BANKS(2), .ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(ld_valid), .o_ld_ready(ldr[0]),
    .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ex_bank_rdy(exr[0]),
    .i_ex_rd_en(ex_rd_en), .i_ex_addr(ex_addr), .o_ex_data(dat_all[7:0]),
    .o_ex_data_vld(vld[0]), .i_ex_done(ex_done), .o_full_cnt(cnt_all[1:0]));

  buf_pp_bank #(.NUM_BANKS(2), .ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LAT(2)) u_lat2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(ld_valid), .o_ld_ready(ldr[1]),
    .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ex_bank_rdy(exr[1]),
    .i_ex_rd_en(ex_rd_en), .i_ex_addr(ex_addr), .o_ex_data(dat_all[15:8]),
    .o_ex_data_vld(vld[1]), .i_ex_done(ex_done), .o_full_cnt(cnt_all[3:2]));

  buf_pp_bank #(.NUM_BANKS(2), .ADDR_WIDTH(10), .DATA_WIDTH(8), .RD_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(ld_valid), .o_ld_ready(ldr[2]),
    .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ex_bank_rdy(exr[2]),
    .i_ex_rd_en(ex_rd_en), .i_ex_addr(ex_addr), .o_ex_data(dat_all[23:16]),
    .o_ex_data_vld(vld[2]), .i_ex_done(ex_done), .o_full_cnt(cnt_all[5:4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (RD_LAT=%0d): got %0h, want %0h", nm, k + 1, act, exp);
    end
  endtask

  task automatic check_state(input logic e_ldr, input logic e_exr, input logic [1:0] e_cnt);
    for (int k = 0; k < 3; k++) begin
      chk("ld_ready", k, 32'(ldr[k]), 32'(e_ldr));
      chk("ex_bank_rdy", k, 32'(exr[k]), 32'(e_exr));
      chk("full_cnt", k, 32'(cnt_all[k*2 +: 2]), 32'(e_cnt));
    end
  endtask

  // Check cycle c (1..3) after a read accept: only the RD_LAT=c instance may show valid.
  task automatic chk_rd(input int c, input logic [7:0] e_dat, input logic e_vld);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ex_data_vld cyc%0d", c), k, 32'(vld[k]), 32'(e_vld && (c == k + 1)));
      if (e_vld && (c == k + 1)) chk("ex_data", k, 32'(dat_all[k*8 +: 8]), 32'(e_dat));
    end
  endtask

  task automatic rd_seq(input logic [9:0] a, input logic [7:0] e_dat, input logic e_vld);
    ex_rd_en = 1'b1;
    ex_addr  = a;
    tick();
    ex_rd_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk_rd(c, e_dat, e_vld);
      if (c < 3) tick();
    end
  endtask

  task automatic add(input logic v, input int a, input int d, input logic last, input logic done,
                     input logic e_ldr, input logic e_exr, input int e_cnt);
    vec_t t;
    t.ld_valid = v;
    t.ld_addr  = 10'(a);
    t.ld_data  = 8'(d);
    t.ld_last  = last;
    t.ex_done  = done;
    t.exp_ldr  = e_ldr;
    t.exp_exr  = e_exr;
    t.exp_cnt  = 2'(e_cnt);
    tbl.push_back(t);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      ld_valid = tbl[i].ld_valid;
      ld_addr  = tbl[i].ld_addr;
      ld_data  = tbl[i].ld_data;
      ld_last  = tbl[i].ld_last;
      ex_done  = tbl[i].ex_done;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ex_done  = 1'b0;
      check_state(tbl[i].exp_ldr, tbl[i].exp_exr, tbl[i].exp_cnt);
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    ex_rd_en = 1'b0; ex_addr = '0; ex_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state.
    check_state(1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) chk("ex_data_vld reset", k, 32'(vld[k]), 32'd0);

    // Stray ld_last / ex_done / ex_rd_en with nothing to act on are ignored.
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    run_tbl();
    rd_seq(10'd5, 8'd0, 1'b0);

    // Fill bank0 with addr i -> i.
    for (int i = 0; i < 16; i++) add(1, i, i, i == 15, 0, 1, i == 15, (i == 15) ? 1 : 0);
    run_tbl();
    rd_seq(10'd5, 8'd5, 1'b1);
    rd_seq(10'd15, 8'd15, 1'b1);
    rd_seq(10'd0, 8'd0, 1'b1);

    // Fill bank1, then a load attempt while all banks are full must stall.
    for (int i = 0; i < 16; i++) add(1, i, 'h80 + i, i == 15, 0, i != 15, 1, (i == 15) ? 2 : 1);
    add(1, 5, 'hEE, 1, 0, 0, 1, 2);
    run_tbl();
    rd_seq(10'd5, 8'd5, 1'b1);

    // Read together with release, then overwrite the same word next cycle: old data returns.
    ex_rd_en = 1'b1; ex_addr = 10'd5; ex_done = 1'b1;
    tick();
    ex_rd_en = 1'b0; ex_done = 1'b0;
    ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 8'hA5;
    chk_rd(1, 8'd5, 1'b1);
    tick();
    ld_valid = 1'b0;
    chk_rd(2, 8'd5, 1'b1);
    tick();
    chk_rd(3, 8'd5, 1'b1);
    check_state(1'b1, 1'b1, 2'd1);
    rd_seq(10'd5, 8'h85, 1'b1);

    // Refill bank0, release bank1 (exec wraps to bank0), read back new bank0 contents.
    for (int i = 0; i < 16; i++) add(1, i, 'h40 + i, i == 15, 0, i != 15, 1, (i == 15) ? 2 : 1);
    add(0, 0, 0, 0, 1, 1, 1, 1);
    run_tbl();
    rd_seq(10'd5, 8'h45, 1'b1);

    // Fill bank1; its completion coincides with release of bank0.
    for (int i = 0; i < 15; i++) add(1, i, 'hC0 + i, 0, 0, 1, 1, 1);
    add(1, 15, 'hCF, 1, 1, 1, 1, 1);
    run_tbl();
    rd_seq(10'd3, 8'hC3, 1'b1);

    // Reset with two reads in flight.
    ex_rd_en = 1'b1; ex_addr = 10'd0;
    tick();
    ex_addr = 10'd1;
    tick();
    ex_rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        chk("ex_data_vld after reset", k, 32'(vld[k]), 32'd0);
        chk("ex_data after reset", k, 32'(dat_all[k*8 +: 8]), 32'd0);
      end
      check_state(1'b1, 1'b0, 2'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
